keycode_pad: RTL and testbench

Maps USB keyboard keycodes onto NES controller ports. Up to `NUM_KEYCODES` keycodes come from the Nios keycode PIO exports, which are concatenated into one bus. A keymap that the CPU can rewrite at runtime turns them into an 8-button state for each of `NUM_PADS` pads. For each pad the block emulates the NES strobe/shift-register serial protocol for the 6502 core at `$4016`/`$4017`. It replaces the fixed three-keycode, single-pad mapping.

---
 rtl/keycode_pad_pkg.sv | 42 ++++
 rtl/keycode_pad_shift.sv | 31 +++
 rtl/keycode_pad.sv | 117 +++++++++++
 tb/tb_keycode_pad.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/keycode_pad_pkg.sv
// Shared types and constants for keycode_pad: button indices, pad state type,
// the power-on keymap for pad 0, and the opposing-direction cleanup helper.
package keycode_pad_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef logic [7:0] pad_state_t;

    // K, J, Space, Enter, W, S, A, D
    localparam logic [7:0] DEFAULT_MAP [8] = '{
        8'h0E, 8'h0D, 8'h2C, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07
    };

    // Drops both members of an opposing pair when both are held.
    function automatic pad_state_t socd_clean(input pad_state_t s);
        pad_state_t r;
        r = s;
        if (s[BTN_LEFT] && s[BTN_RIGHT]) begin
            r[BTN_LEFT]  = 1'b0;
            r[BTN_RIGHT] = 1'b0;
        end else begin
            r[BTN_LEFT]  = s[BTN_LEFT];
            r[BTN_RIGHT] = s[BTN_RIGHT];
        end
        if (s[BTN_UP] && s[BTN_DOWN]) begin
            r[BTN_UP]   = 1'b0;
            r[BTN_DOWN] = 1'b0;
        end else begin
            r[BTN_UP]   = s[BTN_UP];
            r[BTN_DOWN] = s[BTN_DOWN];
        end
        return r;
    endfunction

endpackage

// File: rtl/keycode_pad_shift.sv
// One emulated NES controller: 8-bit strobe/shift register plus the serial
// data mux seen by the CPU.
module keycode_pad_shift
    import keycode_pad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       strobe,
    input  pad_state_t btn,
    input  logic       rd,
    output logic       pad_data
);

    pad_state_t sh_r;

    // Parallel reload while strobed, otherwise shift in ones on each read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_r <= 8'h00;
        end else if (strobe) begin
            sh_r <= btn;
        end else if (rd) begin
            sh_r <= {1'b1, sh_r[7:1]};
        end else begin
            sh_r <= sh_r;
        end
    end

    assign pad_data = strobe ? btn[BTN_A] : sh_r[0];

endmodule

// File: rtl/keycode_pad.sv
// Maps USB keycodes onto NUM_PADS NES controllers through a CPU-writable keymap.
// Define KEYCODE_PAD_SOCD_EN to cancel simultaneous Left+Right / Up+Down.
module keycode_pad
    import keycode_pad_pkg::*;
#(
    parameter int NUM_KEYCODES = 6,
    parameter int NUM_PADS     = 2,
    parameter int KEYCODE_W    = 8
) (
    input  logic                              clk_clk,
    input  logic                              reset_reset,
    input  logic [NUM_KEYCODES*KEYCODE_W-1:0] keycode_export,
    input  logic                              keycode_valid,
    input  logic                              map_we,
    input  logic [$clog2(NUM_PADS*8)-1:0]     map_addr,
    input  logic [KEYCODE_W-1:0]              map_wdata,
    output logic [KEYCODE_W-1:0]              map_rdata,
    input  logic                              strobe_wr,
    input  logic                              strobe_bit,
    input  logic [NUM_PADS-1:0]               pad_rd,
    output logic [NUM_PADS-1:0]               pad_data,
    output logic [NUM_PADS*8-1:0]             buttons
);

    localparam int MAP_N  = NUM_PADS * 8;
    localparam int ADDR_W = $clog2(MAP_N);
    localparam logic [ADDR_W:0] MAP_N_W = (ADDR_W + 1)'(MAP_N);

    logic [KEYCODE_W-1:0] keymap_r [MAP_N];
    logic [MAP_N-1:0]     raw_s;
    logic [MAP_N-1:0]     dec_s;
    logic [MAP_N-1:0]     btn_r;
    logic                 strobe_r;
    logic                 addr_ok_s;

    assign addr_ok_s = ({1'b0, map_addr} < MAP_N_W);

    // Keymap storage; decode in the same cycle as a write still sees the old entry.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < MAP_N; i++) begin
                keymap_r[i] <= (i < 8) ? KEYCODE_W'(DEFAULT_MAP[i[2:0]]) : '0;
            end
        end else if (map_we && addr_ok_s) begin
            keymap_r[map_addr] <= map_wdata;
        end else begin
            keymap_r <= keymap_r;
        end
    end

    // Readback follows map_addr every cycle, forwarding a write to the same slot.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            map_rdata <= '0;
        end else if (!addr_ok_s) begin
            map_rdata <= '0;
        end else if (map_we) begin
            map_rdata <= map_wdata;
        end else begin
            map_rdata <= keymap_r[map_addr];
        end
    end

    // Any non-empty slot equal to a non-zero map entry presses that button.
    always_comb begin
        raw_s = '0;
        for (int e = 0; e < MAP_N; e++) begin
            for (int k = 0; k < NUM_KEYCODES; k++) begin
                raw_s[e] = raw_s[e] |
                    ((keycode_export[k*KEYCODE_W +: KEYCODE_W] != '0) &&
                     (keycode_export[k*KEYCODE_W +: KEYCODE_W] == keymap_r[e]));
            end
        end
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
`ifdef KEYCODE_PAD_SOCD_EN
        assign dec_s[p*8 +: 8] = socd_clean(raw_s[p*8 +: 8]);
`else
        assign dec_s[p*8 +: 8] = raw_s[p*8 +: 8];
`endif

        keycode_pad_shift u_shift (
            .clk      (clk_clk),
            .rst      (reset_reset),
            .strobe   (strobe_r),
            .btn      (btn_r[p*8 +: 8]),
            .rd       (pad_rd[p]),
            .pad_data (pad_data[p])
        );
    end

    // Button state only moves when a complete report arrives.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            btn_r <= '0;
        end else if (keycode_valid) begin
            btn_r <= dec_s;
        end else begin
            btn_r <= btn_r;
        end
    end

    // Strobe latch written by the CPU at $4016.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            strobe_r <= 1'b0;
        end else if (strobe_wr) begin
            strobe_r <= strobe_bit;
        end else begin
            strobe_r <= strobe_r;
        end
    end

    assign buttons = btn_r;

endmodule

// File: tb/tb_keycode_pad.sv
// Directed scoreboard bench for keycode_pad (2 pads, 6 keycodes); honours
// KEYCODE_PAD_SOCD_EN to choose the opposing-direction expectation.
module tb_keycode_pad;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [47:0] keycode_export = '0;
    logic        keycode_valid = 1'b0;
    logic        map_we = 1'b0;
    logic [3:0]  map_addr = 4'd0;
    logic [7:0]  map_wdata = 8'h00;
    logic [7:0]  map_rdata;
    logic        strobe_wr = 1'b0;
    logic        strobe_bit = 1'b0;
    logic [1:0]  pad_rd = 2'b00;
    logic [1:0]  pad_data;
    logic [15:0] buttons;

    keycode_pad #(.NUM_KEYCODES(6), .NUM_PADS(2), .KEYCODE_W(8)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .keycode_export(keycode_export), .keycode_valid(keycode_valid),
        .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata),
        .map_rdata(map_rdata), .strobe_wr(strobe_wr), .strobe_bit(strobe_bit),
        .pad_rd(pad_rd), .pad_data(pad_data), .buttons(buttons)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic report(input logic [7:0] k0, input logic [7:0] k1);
        keycode_export = '0;
        keycode_export[7:0]  = k0;
        keycode_export[15:8] = k1;
        keycode_valid = 1'b1;
        tick();
        keycode_valid = 1'b0;
    endtask

    task automatic strobe(input logic b);
        strobe_wr  = 1'b1;
        strobe_bit = b;
        tick();
        strobe_wr  = 1'b0;
    endtask

    // CPU-style read: sample pad_data in the cycle pad_rd is high.
    task automatic read_pad(input int p, output logic b);
        pad_rd[p] = 1'b1;
        #1;
        b = pad_data[p];
        tick();
        pad_rd = 2'b00;
    endtask

    initial begin
        logic        b;
        logic [9:0]  seq;
        logic [15:0] acc;

        // Reset state
        #1;
        push("rst_buttons", 16'h0000);   check(16'(buttons));
        push("rst_pad_data", 16'h0000);  check(16'(pad_data));
        push("rst_map_rdata", 16'h0000); check(16'(map_rdata));
        tick();
        reset_reset = 1'b0;
        tick();
        push("default_map0", 16'h000E);  check(16'(map_rdata));

        // K + D on pad 0
        report(8'h0E, 8'h07);
        push("kd_buttons", 16'h0081);    check(buttons);

        strobe(1'b1);
        strobe(1'b0);
        seq = 10'b11_1000_0001;
        for (int i = 0; i < 10; i++) begin
            push($sformatf("kd_read%0d", i), 16'(seq[i]));
            read_pad(0, b);
            check(16'(b));
        end

        // Report while strobe is high: data tracks A only
        strobe(1'b1);
        push("strobe_hi_a", 16'h0001);   check(16'(pad_data[0]));
        report(8'h28, 8'h00);
        push("start_a_low0", 16'h0000);  check(16'(pad_data[0]));
        tick();
        tick();
        push("start_a_low1", 16'h0000);  check(16'(pad_data[0]));
        strobe(1'b0);
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            read_pad(0, b);
            acc[i] = b;
        end
        push("start_reads", 16'h0008);   check(acc);

        // Rebind pad 1 A to K
        map_addr  = 4'd8;
        map_wdata = 8'h0E;
        map_we    = 1'b1;
        tick();
        map_we    = 1'b0;
        push("map8_rdata", 16'h000E);    check(16'(map_rdata));
        report(8'h0E, 8'h00);
        push("two_pad_buttons", 16'h0101); check(buttons);
        strobe(1'b1);
        strobe(1'b0);
        push("pad1_read0", 16'h0001);
        read_pad(1, b);
        check(16'(b));
        push("pad1_read1", 16'h0000);
        read_pad(1, b);
        check(16'(b));

        // Left + Right together
        report(8'h04, 8'h07);
`ifdef KEYCODE_PAD_SOCD_EN
        push("socd_buttons", 16'h0000);
`else
        push("socd_buttons", 16'h00C0);
`endif
        check(buttons);

        // Reset after 3 reads of a strobed sequence
        report(8'h0E, 8'h07);
        strobe(1'b1);
        strobe(1'b0);
        for (int i = 0; i < 3; i++) begin
            read_pad(0, b);
        end
        reset_reset = 1'b1;
        #1;
        push("midrst_pad_data", 16'h0000); check(16'(pad_data));
        tick();
        reset_reset = 1'b0;
        tick();
        push("midrst_map8", 16'h0000);   check(16'(map_rdata));
        map_addr = 4'd0;
        tick();
        push("midrst_map0", 16'h000E);   check(16'(map_rdata));
        push("midrst_read", 16'h0000);
        read_pad(0, b);
        check(16'(b));
        strobe(1'b1);
        strobe(1'b0);
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            read_pad(0, b);
            acc[i] = b;
        end
        push("midrst_restrobe", 16'h0000); check(acc);

        // Strobe write and read in the same cycle
        report(8'h0E, 8'h00);
        strobe(1'b1);
        strobe(1'b0);
        read_pad(0, b);
        read_pad(0, b);
        strobe_wr  = 1'b1;
        strobe_bit = 1'b1;
        pad_rd[0]  = 1'b1;
        #1;
        push("same_cycle_old", 16'h0000); check(16'(pad_data[0]));
        tick();
        strobe_wr = 1'b0;
        pad_rd    = 2'b00;
        push("same_cycle_new", 16'h0001); check(16'(pad_data[0]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
